// File: rtl/scope_sample_timer_pkg.sv
// Shared definitions for the scope sample timer: state encodings and default capture length.
package scope_sample_timer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Default capture length, shared with the capture FIFO depth and display width.
   localparam int NUM_SAMPLES_DEF = 480;

   // A zero period would never tick, so it is treated as one clock.
   function automatic logic [31:0] eff_period(input logic [31:0] p);
      return (p == 32'd0) ? 32'd1 : p;
   endfunction

endpackage

// File: rtl/scope_sample_timer_if.sv
// Control/status bundle between the trig_period PIO side and the capture timer.
interface scope_sample_timer_if #(
   parameter int PERIOD_W = 32,
   parameter int IDX_W    = 16
);
   logic [PERIOD_W-1:0] period;
   logic                start;
   logic                abort;
   logic                sample_tick;
   logic [IDX_W-1:0]    sample_idx;
   logic                busy;
   logic                done;

   modport master (
      output period, start, abort,
      input  sample_tick, sample_idx, busy, done
   );

   modport slave (
      input  period, start, abort,
      output sample_tick, sample_idx, busy, done
   );
endinterface

// File: rtl/scope_sample_timer_counter.sv
// Period down-counter with load, enable and terminal count; reusable for trigger holdoff.
module scope_sample_timer_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign tc = (cnt == '0);
endmodule

// File: rtl/scope_sample_timer.sv
// Sample tick generator: one tick every latched period for a fixed-length capture, then done.
// state   | meaning
// ST_IDLE | waiting for start; outputs quiet
// ST_RUN  | counting periods; tick on terminal count, done after last sample
module scope_sample_timer
   import scope_sample_timer_pkg::*;
#(
   parameter int PERIOD_W    = 32,
   parameter int IDX_W       = 16,
   parameter int NUM_SAMPLES = NUM_SAMPLES_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   scope_sample_timer_if.slave bus
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

   state_t              state, state_nxt;
   logic [PERIOD_W-1:0] shadow;
   logic [PERIOD_W-1:0] p_eff;
   logic [PERIOD_W-1:0] ld_val;
   logic [IDX_W-1:0]    idx;
   logic                ld, en, tc, tick, fin, start_acc, adv, done_q;

   assign p_eff = PERIOD_W'(eff_period(32'(bus.period)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         shadow <= PERIOD_W'(1);
         idx    <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= fin;
         if (start_acc) begin
            shadow <= p_eff;
            idx    <= '0;
         end else if (adv) begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Abort overrides everything, including the tick and the final-sample transition.
   always_comb begin
      state_nxt = state;
      ld        = 1'b0;
      ld_val    = shadow - 1'b1;
      en        = 1'b0;
      tick      = 1'b0;
      fin       = 1'b0;
      start_acc = 1'b0;
      adv       = 1'b0;
      if (bus.abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state_nxt = ST_RUN;
                  start_acc = 1'b1;
                  ld        = 1'b1;
                  ld_val    = p_eff - 1'b1;
               end
            end
            ST_RUN: begin
               if (tc) begin
                  tick = 1'b1;
                  if (idx == LAST_IDX) begin
                     state_nxt = ST_IDLE;
                     fin       = 1'b1;
                  end else begin
                     ld  = 1'b1;
                     adv = 1'b1;
                  end
               end else begin
                  en = 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   scope_sample_timer_counter #(.W(PERIOD_W)) u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (bus.abort),
      .load     (ld),
      .load_val (ld_val),
      .en       (en),
      .tc       (tc)
   );

   assign bus.sample_tick = tick;
   assign bus.sample_idx  = idx;
   assign bus.busy        = (state == ST_RUN);
   assign bus.done        = done_q;
endmodule
